// File: rtl/hiscore_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hiscore_ram_arbiter
// Purpose  : Pauses the game CPU and hands the work-RAM port to the hiscore
//            engine for the duration of a hiscore access request.
// Revision : 1.0 - initial release
// ============================================================================
module hiscore_ram_arbiter #(
    parameter int HS_ADDRESSWIDTH = 10,
    parameter int SETTLE_CYCLES   = 4,
    parameter int RELEASE_CYCLES  = 2,
    parameter int USE_ACK         = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [HS_ADDRESSWIDTH-1:0] hs_address,
    input  logic [7:0]                 hs_data_in,
    input  logic                       hs_write,
    input  logic                       hs_access,
    output logic [7:0]                 hs_data_out,
    output logic                       hs_granted,
    input  logic [HS_ADDRESSWIDTH-1:0] cpu_address,
    input  logic [7:0]                 cpu_data_in,
    input  logic                       cpu_write,
    input  logic                       cpu_pause_ack,
    output logic                       pause_cpu,
    output logic [HS_ADDRESSWIDTH-1:0] ram_address,
    output logic [7:0]                 ram_data_out,
    output logic                       ram_we,
    input  logic [7:0]                 ram_q,
    output logic                       write_dropped
);

    localparam logic [7:0] c_settle_load  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] c_release_load = 8'(RELEASE_CYCLES - 1);
    localparam logic       c_ignore_ack   = (USE_ACK == 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PAUSE_REQ = 3'd1,
        SETTLE    = 3'd2,
        GRANT     = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_pause_cpu;
    logic       r_hs_granted;
    logic       r_write_dropped;
    logic [7:0] r_hs_data_out;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (hs_access) begin
                    w_state_nxt = PAUSE_REQ;
                end
            end
            PAUSE_REQ: begin
                if (!hs_access) begin
                    w_state_nxt = IDLE;
                end else if (cpu_pause_ack || c_ignore_ack) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = c_settle_load;
                end
            end
            SETTLE: begin
                // Losing the ack mid-settle means the CPU is running again,
                // so the settle window has to start over from PAUSE_REQ.
                if (!hs_access) begin
                    w_state_nxt = IDLE;
                end else if (!c_ignore_ack && !cpu_pause_ack) begin
                    w_state_nxt = PAUSE_REQ;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = GRANT;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            GRANT: begin
                if (!hs_access) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = c_release_load;
                end
            end
            RELEASE: begin
                if (hs_access) begin
                    w_state_nxt = GRANT;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_pause_cpu  <= 1'b0;
            r_hs_granted <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pause_cpu  <= (w_state_nxt != IDLE);
            r_hs_granted <= (w_state_nxt == GRANT) || (w_state_nxt == RELEASE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write_dropped <= 1'b0;
            r_hs_data_out   <= 8'd0;
        end else begin
            if (hs_write && !r_hs_granted) begin
                r_write_dropped <= 1'b1;
            end
            if (r_hs_granted) begin
                r_hs_data_out <= ram_q;
            end
        end
    end

    // Mux keys off the registered grant so the RAM port never glitches mid-cycle.
    always_comb begin
        if (r_hs_granted) begin
            ram_address  = hs_address;
            ram_data_out = hs_data_in;
            ram_we       = hs_write;
        end else begin
            ram_address  = cpu_address;
            ram_data_out = cpu_data_in;
            ram_we       = cpu_write;
        end
    end

    assign pause_cpu     = r_pause_cpu;
    assign hs_granted    = r_hs_granted;
    assign write_dropped = r_write_dropped;
    assign hs_data_out   = r_hs_data_out;

endmodule
`default_nettype wire
